// File: rtl/ascii_ram_write_ctrl_if.sv
// CPU store bus carrying byte writes toward the text-mode RAM controller.
// The master drives the store; the slave answers with ready.
interface ascii_ram_write_ctrl_if;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [7:0]  bus_data;
  logic        bus_ready;

  modport master (output bus_we, bus_addr, bus_data, input bus_ready);
  modport slave  (input bus_we, bus_addr, bus_data, output bus_ready);
endinterface

// File: rtl/ascii_ram_write_ctrl.sv
// Queues CPU stores into the text window, converts each linear index to a
// {row, col} address by repeated subtraction, and runs a clear-screen sweep.
module ascii_ram_write_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFEF_FE00,
  parameter int          COL_NUM    = 80,
  parameter int          ROW_NUM    = 30,
  parameter int          COL_BIT    = 7,
  parameter int          ROW_BIT    = 5,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  CLR_CHAR   = 8'h20
) (
  input  logic                       clk,
  input  logic                       rst,
  ascii_ram_write_ctrl_if.slave      bus,
  input  logic                       i_clr_req,
  output logic                       o_busy,
  output logic                       o_ram_we,
  output logic [ROW_BIT+COL_BIT-1:0] o_ram_addr,
  output logic [7:0]                 o_ram_data,
  output logic                       o_err_oob
);

  localparam int IDX_W = 12;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IDX_W + 8;

  localparam logic [31:0]        L_CELLS    = 32'(COL_NUM * ROW_NUM);
  localparam logic [IDX_W-1:0]   L_COLS     = IDX_W'(COL_NUM);
  localparam logic [COL_BIT-1:0] L_COL_LAST = COL_BIT'(COL_NUM - 1);
  localparam logic [ROW_BIT-1:0] L_ROW_LAST = ROW_BIT'(ROW_NUM - 1);
  localparam logic [CNT_W-1:0]   L_DEPTH    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_WRITE, S_CLEAR} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ENT_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_clr_pending;

  logic [IDX_W-1:0]   r_rem;
  logic [ROW_BIT-1:0] r_row;
  logic [7:0]         r_char;

  logic [ROW_BIT+COL_BIT-1:0] r_ram_addr;
  logic [7:0]                 r_ram_data;
  logic                       r_err_oob;

  logic [31:0]                w_idx;
  logic                       w_in_win;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_accept;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_div_done;
  logic [ROW_BIT-1:0]         w_clr_row;
  logic [COL_BIT-1:0]         w_clr_col;
  logic                       w_last_cell;
  logic [ROW_BIT+COL_BIT-1:0] w_clr_next;

  assign w_idx    = bus.bus_addr - BASE_ADDR;
  assign w_in_win = (w_idx < L_CELLS);
  assign w_full   = (r_count == L_DEPTH);
  assign w_empty  = (r_count == '0);

  // Ready comes from registered occupancy, so a pop does not reopen the bus in the same cycle.
  assign bus.bus_ready = !w_full && !r_clr_pending && (r_state != S_CLEAR);

  // A store colliding with a clear request is dropped along with the flushed queue.
  assign w_accept   = bus.bus_we && bus.bus_ready && !i_clr_req;
  assign w_push     = w_accept && w_in_win;
  assign w_pop      = (r_state == S_IDLE) && !r_clr_pending && !w_empty && !i_clr_req;
  assign w_div_done = (r_rem < L_COLS);

  assign w_clr_row   = r_ram_addr[ROW_BIT+COL_BIT-1:COL_BIT];
  assign w_clr_col   = r_ram_addr[COL_BIT-1:0];
  assign w_last_cell = (w_clr_row == L_ROW_LAST) && (w_clr_col == L_COL_LAST);

  always_comb begin
    w_clr_next = r_ram_addr;
    if (w_clr_col == L_COL_LAST) begin
      w_clr_next = {w_clr_row + 1'b1, {COL_BIT{1'b0}}};
    end else begin
      w_clr_next = {w_clr_row, w_clr_col + 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr_req) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {w_idx[IDX_W-1:0], bus.bus_data};
  end

  // A request arriving during a sweep re-arms the flag for one more sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_pending <= 1'b0;
    end else if (i_clr_req) begin
      r_clr_pending <= 1'b1;
    end else if (r_state == S_IDLE) begin
      r_clr_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_clr_pending) w_state_nxt = S_CLEAR;
        else if (w_pop)    w_state_nxt = S_DIV;
      end
      S_DIV:   if (w_div_done) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      S_CLEAR: if (w_last_cell) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_pop) begin
      {r_rem, r_char} <= r_fifo[r_rd_ptr];
      r_row           <= '0;
    end else if ((r_state == S_DIV) && !w_div_done) begin
      r_rem <= r_rem - L_COLS;
      r_row <= r_row + 1'b1;
    end
  end

  // Output address/data registers change only on entry to a write; otherwise they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_err_oob  <= 1'b0;
    end else begin
      r_err_oob <= w_accept && !w_in_win;
      case (r_state)
        S_IDLE: begin
          if (r_clr_pending) begin
            r_ram_addr <= '0;
            r_ram_data <= CLR_CHAR;
          end
        end
        S_DIV: begin
          if (w_div_done) begin
            r_ram_addr <= {r_row, r_rem[COL_BIT-1:0]};
            r_ram_data <= r_char;
          end
        end
        S_CLEAR: if (!w_last_cell) r_ram_addr <= w_clr_next;
        default: ;
      endcase
    end
  end

  assign o_ram_we   = (r_state == S_WRITE) || (r_state == S_CLEAR);
  assign o_ram_addr = r_ram_addr;
  assign o_ram_data = r_ram_data;
  assign o_err_oob  = r_err_oob;
  assign o_busy     = (r_state != S_IDLE) || !w_empty || r_clr_pending;

endmodule

// File: tb/tb_ascii_ram_write_ctrl.sv
// Directed bench for ascii_ram_write_ctrl: latency, window decode, queue
// back-pressure, clear sweep and reset during a sweep.
module tb_ascii_ram_write_ctrl;

  localparam logic [31:0] BASE = 32'hFFEF_FE00;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_req = 1'b0;
  logic        busy;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        err_oob;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  wr_t wq[$];

  int         b_idx[8];
  logic [7:0] b_dat[8];

  ascii_ram_write_ctrl_if bus_if();

  ascii_ram_write_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .i_clr_req  (clr_req),
    .o_busy     (busy),
    .o_ram_we   (ram_we),
    .o_ram_addr (ram_addr),
    .o_ram_data (ram_data),
    .o_err_oob  (err_oob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we === 1'b1) wq.push_back('{ram_addr, ram_data, cyc});
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [7:0] d,
                          output int acc, output bit ok);
    ok  = 1'b0;
    acc = 0;
    tick();
    bus_if.bus_we   = 1'b1;
    bus_if.bus_addr = a;
    bus_if.bus_data = d;
    for (int k = 0; k < 100; k++) begin
      if (bus_if.bus_ready === 1'b1) begin
        acc = cyc + 1;
        ok  = 1'b1;
        break;
      end
      tick();
    end
    tick();
    bus_if.bus_we = 1'b0;
  endtask

  task automatic push_burst(input int n, output int stalls, output int acc_n);
    acc_n  = 0;
    stalls = 0;
    for (int k = 0; k < 400 && acc_n < n; k++) begin
      tick();
      bus_if.bus_we   = 1'b1;
      bus_if.bus_addr = BASE + 32'(b_idx[acc_n]);
      bus_if.bus_data = b_dat[acc_n];
      if (bus_if.bus_ready === 1'b1) acc_n++;
      else stalls++;
    end
    tick();
    bus_if.bus_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.bus_we = 1'b0;
    bus_if.bus_addr = '0;
    bus_if.bus_data = '0;
    clr_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    n_tests++;
    if (bus_if.bus_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_first: got %b expected 1", bus_if.bus_ready);
    end
    repeat (5) tick();
    n_tests++;
    if (bus_if.bus_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", bus_if.bus_ready);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++;
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
    n_tests++;
    if (err_oob !== 1'b0) begin n_fail++; $display("FAIL reset_err_oob: got %b expected 0", err_oob); end
    n_tests++;
    if (ram_addr !== 12'd0) begin n_fail++; $display("FAIL reset_ram_addr: got %h expected 000", ram_addr); end
    n_tests++;
    if (ram_data !== 8'd0) begin n_fail++; $display("FAIL reset_ram_data: got %h expected 00", ram_data); end
  endtask

  task automatic test_latency();
    int          v_idx[3]  = '{0, 2399, 80};
    logic [7:0]  v_dat[3]  = '{8'h41, 8'h5A, 8'h42};
    logic [11:0] v_addr[3] = '{{5'd0, 7'd0}, {5'd29, 7'd79}, {5'd1, 7'd0}};
    int          v_lat[3]  = '{3, 32, 4};
    int acc;
    bit ok;
    for (int v = 0; v < 3; v++) begin
      wq.delete();
      do_store(BASE + 32'(v_idx[v]), v_dat[v], acc, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL lat%0d_accept: store not accepted", v); end
      for (int k = 0; k < 60 && wq.size() == 0; k++) tick();
      repeat (5) tick();
      n_tests++;
      if (wq.size() != 1) begin
        n_fail++; $display("FAIL lat%0d_count: got %0d writes expected 1", v, wq.size());
      end
      if (wq.size() >= 1) begin
        n_tests++;
        if (wq[0].addr !== v_addr[v]) begin
          n_fail++; $display("FAIL lat%0d_addr: got %h expected %h", v, wq[0].addr, v_addr[v]);
        end
        n_tests++;
        if (wq[0].data !== v_dat[v]) begin
          n_fail++; $display("FAIL lat%0d_data: got %h expected %h", v, wq[0].data, v_dat[v]);
        end
        n_tests++;
        if (wq[0].cyc + 1 - acc != v_lat[v]) begin
          n_fail++; $display("FAIL lat%0d_cycles: got %0d expected %0d", v, wq[0].cyc + 1 - acc, v_lat[v]);
        end
      end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL lat%0d_busy_after: got %b expected 0", v, busy); end
    end
  endtask

  task automatic test_oob();
    logic [31:0] v_a[2] = '{BASE + 32'd2400, 32'hFFEF_FDFF};
    int acc;
    bit ok;
    for (int v = 0; v < 2; v++) begin
      wq.delete();
      do_store(v_a[v], 8'h55, acc, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL oob%0d_accept: store not accepted", v); end
      n_tests++;
      if (err_oob !== 1'b1) begin n_fail++; $display("FAIL oob%0d_pulse: got %b expected 1", v, err_oob); end
      tick();
      n_tests++;
      if (err_oob !== 1'b0) begin n_fail++; $display("FAIL oob%0d_pulse_end: got %b expected 0", v, err_oob); end
      repeat (10) tick();
      n_tests++;
      if (wq.size() != 0) begin n_fail++; $display("FAIL oob%0d_writes: got %0d expected 0", v, wq.size()); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL oob%0d_fifo: busy got %b expected 0", v, busy); end
    end
  endtask

  task automatic test_back_to_back();
    int acc, stalls, acc_n;
    bit ok;
    wq.delete();
    do_store(BASE + 32'd2399, 8'h7E, acc, ok);
    for (int i = 0; i < 6; i++) begin
      b_idx[i] = i + 1;
      b_dat[i] = 8'h61 + 8'(i);
    end
    push_burst(6, stalls, acc_n);
    n_tests++;
    if (!ok || acc_n != 6) begin
      n_fail++; $display("FAIL b2b_accepted: got %0d expected 6", acc_n);
    end
    n_tests++;
    if (stalls == 0) begin n_fail++; $display("FAIL b2b_ready_drop: got 0 stall cycles expected >0"); end
    for (int k = 0; k < 300 && wq.size() < 7; k++) tick();
    repeat (5) tick();
    n_tests++;
    if (wq.size() != 7) begin n_fail++; $display("FAIL b2b_count: got %0d expected 7", wq.size()); end
    if (wq.size() == 7) begin
      n_tests++;
      if (wq[0].addr !== {5'd29, 7'd79}) begin
        n_fail++; $display("FAIL b2b_first_addr: got %h expected %h", wq[0].addr, {5'd29, 7'd79});
      end
      for (int i = 1; i <= 6; i++) begin
        n_tests++;
        if (wq[i].addr !== {5'd0, 7'(i)} || wq[i].data !== 8'h60 + 8'(i)) begin
          n_fail++;
          $display("FAIL b2b_write%0d: got %h/%h expected %h/%h", i, wq[i].addr, wq[i].data,
                   {5'd0, 7'(i)}, 8'h60 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_clear();
    int stalls, acc_n, bad_ready, bad_busy, clr_err, first_bad, wait_cyc;
    logic [11:0] exp_a;
    wq.delete();
    b_idx[0] = 200; b_dat[0] = 8'h77;
    b_idx[1] = 10;  b_dat[1] = 8'h78;
    b_idx[2] = 20;  b_dat[2] = 8'h79;
    push_burst(3, stalls, acc_n);
    n_tests++;
    if (acc_n != 3 || stalls != 0) begin
      n_fail++; $display("FAIL clr_queue: got %0d accepted %0d stalls expected 3/0", acc_n, stalls);
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    bad_ready = 0;
    bad_busy  = 0;
    wait_cyc  = 0;
    while (busy === 1'b1 && wait_cyc < 3000) begin
      if (bus_if.bus_ready !== 1'b0) bad_ready++;
      tick();
      wait_cyc++;
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_done: busy got %b expected 0", busy); bad_busy = 1; end
    n_tests++;
    if (bad_ready != 0) begin n_fail++; $display("FAIL clr_ready_low: got %0d ready cycles expected 0", bad_ready); end
    n_tests++;
    if (wq.size() != 2401) begin n_fail++; $display("FAIL clr_count: got %0d writes expected 2401", wq.size()); end
    if (wq.size() == 2401) begin
      n_tests++;
      if (wq[0].addr !== {5'd2, 7'd40} || wq[0].data !== 8'h77) begin
        n_fail++; $display("FAIL clr_pending_write: got %h/%h expected %h/77", wq[0].addr, wq[0].data, {5'd2, 7'd40});
      end
      clr_err = 0;
      first_bad = -1;
      for (int k = 0; k < 2400; k++) begin
        exp_a = {5'(k / 80), 7'(k % 80)};
        if (wq[k+1].addr !== exp_a || wq[k+1].data !== 8'h20 ||
            (k > 0 && wq[k+1].cyc != wq[k].cyc + 1)) begin
          clr_err++;
          if (first_bad < 0) first_bad = k;
        end
      end
      n_tests++;
      if (clr_err != 0) begin
        n_fail++; $display("FAIL clr_sweep: got %0d bad cells (first %0d) expected 0", clr_err, first_bad);
      end
    end
    if (bad_busy == 0) begin
      repeat (5) tick();
      n_tests++;
      if (wq.size() != 2401 || ram_addr !== {5'd29, 7'd79} || ram_data !== 8'h20) begin
        n_fail++; $display("FAIL clr_hold: got %0d writes addr %h data %h expected 2401 %h 20",
                           wq.size(), ram_addr, ram_data, {5'd29, 7'd79});
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int snap;
    wq.delete();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 1200 && wq.size() < 1000; k++) tick();
    n_tests++;
    if (wq.size() != 1000) begin n_fail++; $display("FAIL mid_reach: got %0d writes expected 1000", wq.size()); end
    rst = 1'b1;
    tick();
    n_tests++;
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL mid_ram_we: got %b expected 0", ram_we); end
    n_tests++;
    if (ram_addr !== 12'd0 || ram_data !== 8'd0) begin
      n_fail++; $display("FAIL mid_ram_bus: got %h/%h expected 000/00", ram_addr, ram_data);
    end
    n_tests++;
    if (busy !== 1'b0 || err_oob !== 1'b0 || bus_if.bus_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_status: got busy %b oob %b ready %b expected 0 0 1", busy, err_oob, bus_if.bus_ready);
    end
    rst = 1'b0;
    snap = wq.size();
    repeat (20) tick();
    n_tests++;
    if (wq.size() != snap) begin n_fail++; $display("FAIL mid_no_resume: got %0d writes expected %0d", wq.size(), snap); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle: busy got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_oob();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ascii_ram_write_ctrl.md
Name: ascii_ram_write_ctrl

Overview:
Sequences CPU byte stores into the text-mode ASCII RAM that feeds the display. Decodes bus writes in the memory-mapped text window and queues them in a small FIFO. Converts each linear character index into a {row, col} RAM address with an iterative subtract-by-COL_NUM divider, then issues single-cycle RAM writes. Also owns a clear-screen engine that sweeps every cell with a space character.

Parameters:
BASE_ADDR, 32'hFFEF_FE00, byte address of text cell (0,0) on CPU bus
COL_NUM, 80, characters per row
ROW_NUM, 30, rows on screen
COL_BIT, 7, column field width of RAM address
ROW_BIT, 5, row field width of RAM address
FIFO_DEPTH, 4, queued store entries (power of 2)
CLR_CHAR, 8'h20, character written by clear sweep

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
bus_we  in  1  CPU store strobe, one cycle per store
bus_addr  in  32  CPU store byte address
bus_data  in  8  character code
bus_ready  out  1  store accepted this cycle when bus_we & bus_ready
clr_req  in  1  clear-screen request pulse
busy  out  1  FSM not IDLE, or FIFO non-empty, or clear pending
ram_we  out  1  text RAM write strobe
ram_addr  out  ROW_BIT+COL_BIT  {row, col}
ram_data  out  8  text RAM write data
err_oob  out  1  one-cycle pulse: accepted store outside window

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous, active-high.
- Reset: FSM=IDLE, FIFO empty, clear-pending=0. ram_we=0, ram_addr=0, ram_data=0, err_oob=0, busy=0. bus_ready=1 in the first cycle after reset.
- bus_ready = !fifo_full & !clr_pending & (state!=CLEAR). A store is accepted only when bus_we & bus_ready. A bus_we while bus_ready=0 is ignored; the requester holds it.
- Window decode on acceptance: idx = bus_addr - BASE_ADDR, 32-bit unsigned with wrap. The store is in window iff idx < COL_NUM*ROW_NUM (2400).
  - In window: push {idx[11:0], bus_data}.
  - Out of window: not pushed; err_oob=1 in the next cycle only.
- clr_req: sets clr_pending. Also flushes the FIFO at the same edge, discarding queued entries. A store presented in the same cycle as clr_req is dropped.
- FSM states:
  - IDLE: if clr_pending, go to CLEAR with row=0, col=0 and clear clr_pending. Else if FIFO non-empty, pop and load rem=idx, row=0, latch data, go to DIV. Clear has priority.
  - DIV: one step per cycle. If rem>=COL_NUM: rem-=COL_NUM, row++. Else go to WRITE. Takes floor(idx/80)+1 cycles.
  - WRITE: ram_we=1 for exactly one cycle with ram_addr={row[ROW_BIT-1:0], rem[COL_BIT-1:0]} and ram_data=latched char. Then go to IDLE.
  - CLEAR: ram_we=1 every cycle with ram_data=CLR_CHAR and ram_addr={row,col}. col increments and wraps at COL_NUM-1 to 0 with row++. After {ROW_NUM-1, COL_NUM-1}, go to IDLE. That is exactly 2400 consecutive write cycles.
- clr_req during CLEAR re-arms clr_pending, so one more full sweep runs afterwards. clr_req during DIV/WRITE lets the current write complete; the clear follows.
- Latency: with FSM idle and FIFO empty, a store accepted at edge N produces its ram_we in cycle N+3+floor(idx/80). Index 0 → N+3; index 2399 → N+32.
- Writes are performed in acceptance order. Simultaneous push and pop are allowed when full: the pop frees the slot at the same edge, but bus_ready stays 0 that cycle because it is computed from registered full.
- ram_addr and ram_data hold their last value when ram_we=0. ram_we never asserts outside WRITE or CLEAR.
- Reset mid-DIV or mid-CLEAR: returns to the reset state at that edge. The sweep does not resume.

Test Plan:
- Reset, then idle 5 cycles → bus_ready=1, busy=0, ram_we=0, err_oob=0, ram_addr=0.
- Store 0xFFEF_FE00 data 8'h41 → one ram_we 3 cycles later, ram_addr={5'd0,7'd0}, ram_data=8'h41. Store 0xFFEF_FE00+2399 → ram_we 32 cycles after acceptance, ram_addr={5'd29,7'd79}. Store +80 → {5'd1,7'd0}.
- Stores to 0xFFEF_FE00+2400 and 0xFFEF_FDFF → no ram_we, err_oob pulses exactly one cycle after each acceptance, FIFO unchanged.
- Back-to-back bus_we to indices 1,2,3,4,5,6 → bus_ready drops once 4 entries are queued. The held store is accepted later. Six ram_we appear in order with cols 1..6, row 0, and no data lost.
- Queue 3 stores, pulse clr_req while the first is in DIV → that write completes, the other 2 are discarded. Exactly 2400 consecutive ram_we of 8'h20 follow, addresses {0,0}..{29,79} row-major. bus_ready=0 and busy=1 throughout, then busy=0.
- Assert rst at sweep cycle 1000 → next cycle ram_we=0, all outputs at reset values, no further writes until new requests.
